// File: rtl/aes_inv_sbyte_seq_pkg.sv
// Shared constants (aes_const) and types (aes_wire) for the AES inverse SubBytes engine.
// Inv_S_Box is derived at elaboration from the GF(2^8) definition of the forward S-box.
package aes_const;
   localparam int Nb          = 4;
   localparam int STATE_BYTES = 4 * Nb;

   function automatic logic [255:0][7:0] calc_inv_sbox();
      logic [255:0][7:0] fwd;
      logic [255:0][7:0] inv;
      logic [7:0]        p;
      logic [7:0]        q;
      logic [7:0]        x;
      fwd    = '0;
      inv    = '0;
      p      = 8'h01;
      q      = 8'h01;
      fwd[0] = 8'h63;
      // Walk the multiplicative group with generator 3 while q tracks p^-1.
      for (int i = 0; i < 255; i++) begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         fwd[p] = x ^ 8'h63;
      end
      for (int i = 0; i < 256; i++) inv[fwd[i]] = 8'(i);
      return inv;
   endfunction

   localparam logic [255:0][7:0] Inv_S_Box = calc_inv_sbox();
endpackage

package aes_wire;
   import aes_const::*;

   typedef enum logic [1:0] {
      BUILD,
      IDLE,
      PROC,
      DONE
   } fsm_e;

   typedef logic [STATE_BYTES-1:0][7:0] state_t;
endpackage

// File: rtl/aes_inv_sbyte_seq_table.sv
// Inverse S-box store: one write port, LANES combinational read ports.
// With AES_INV_TABLE_BUILD_EN it is a writable 256x8 array, otherwise the constant Inv_S_Box.
module aes_inv_table
   import aes_const::*;
#(
   parameter int LANES = 4
) (
   input  logic                  clock,
   input  logic                  wr_en,
   input  logic [7:0]            wr_addr,
   input  logic [7:0]            wr_data,
   input  logic [LANES-1:0][7:0] rd_addr,
   output logic [LANES-1:0][7:0] rd_data
);

`ifdef AES_INV_TABLE_BUILD_EN
   // No reset: every entry is rewritten during BUILD before it can be read.
   logic [7:0] inv_q [256];

   always_ff @(posedge clock) begin
      if (wr_en) inv_q[wr_addr] <= wr_data;
   end

   always_comb begin
      rd_data = '0;
      for (int l = 0; l < LANES; l++) rd_data[l] = inv_q[rd_addr[l]];
   end
`else
   logic unused_wr;
   assign unused_wr = ^{clock, wr_en, wr_addr, wr_data};

   always_comb begin
      rd_data = '0;
      for (int l = 0; l < LANES; l++) rd_data[l] = Inv_S_Box[rd_addr[l]];
   end
`endif

endmodule

// File: rtl/aes_inv_sbyte_seq.sv
// Sequential AES InvSubBytes over a 16-byte state, LANES bytes per cycle.
// Define AES_INV_TABLE_BUILD_EN to derive the inverse table from S_Box after reset.
module aes_inv_sbyte_seq
   import aes_const::*;
   import aes_wire::*;
#(
   parameter int LANES = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [255:0][7:0] S_Box,
   input  logic              in_valid,
   output logic              in_ready,
   input  state_t            State_in,
   output logic              out_valid,
   input  logic              out_ready,
   output state_t            State_out,
   output logic              table_ok
);

   localparam int         NSTEP    = STATE_BYTES / LANES;
   localparam logic [3:0] LAST_IDX = 4'(NSTEP - 1);

   fsm_e                  state_q, state_d;
   logic [3:0]            idx_q, idx_d;
   state_t                blk_q, blk_d;
   logic                  out_valid_q, out_valid_d;
   logic                  table_ok_q, table_ok_d;
   logic                  wr_en;
   logic [7:0]            wr_addr, wr_data;
   logic [LANES-1:0][7:0] rd_addr, rd_data;

   function automatic logic [3:0] lane_pos(input logic [3:0] idx, input int lane);
      return 4'(int'(idx) * LANES + lane);
   endfunction

`ifdef AES_INV_TABLE_BUILD_EN
   localparam fsm_e RESET_STATE = BUILD;
   logic [7:0] k_q, k_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) k_q <= '0;
      else       k_q <= k_d;
   end
`else
   localparam fsm_e RESET_STATE = IDLE;
   logic unused_sbox;
   assign unused_sbox = ^S_Box;
`endif

   aes_inv_table #(.LANES(LANES)) u_table (
      .clock   (clock),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_comb begin
      rd_addr = '0;
      for (int l = 0; l < LANES; l++) rd_addr[l] = blk_q[lane_pos(idx_q, l)];
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      blk_d       = blk_q;
      out_valid_d = 1'b0;
      table_ok_d  = table_ok_q;
      wr_en       = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
`ifdef AES_INV_TABLE_BUILD_EN
      k_d         = k_q;
`endif
      case (state_q)
         BUILD: begin
`ifdef AES_INV_TABLE_BUILD_EN
            wr_en   = 1'b1;
            wr_addr = S_Box[k_q];
            wr_data = k_q;
            k_d     = k_q + 8'd1;
            if (k_q == 8'hFF) begin
               state_d    = IDLE;
               table_ok_d = 1'b1;
            end
`else
            state_d = IDLE;
`endif
         end
         IDLE: begin
            table_ok_d = 1'b1;
            if (in_valid && in_ready) begin
               blk_d   = State_in;
               idx_d   = '0;
               state_d = PROC;
            end
         end
         PROC: begin
            for (int l = 0; l < LANES; l++) blk_d[lane_pos(idx_q, l)] = rd_data[l];
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         DONE: begin
            // out_valid trails DONE entry by one cycle, giving the NSTEP+1 latency.
            if (out_valid_q && out_ready) state_d = IDLE;
            else                          out_valid_d = 1'b1;
         end
         default: state_d = RESET_STATE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= RESET_STATE;
         idx_q       <= '0;
         blk_q       <= '0;
         out_valid_q <= 1'b0;
         table_ok_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         blk_q       <= blk_d;
         out_valid_q <= out_valid_d;
         table_ok_q  <= table_ok_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && table_ok_q;
   assign out_valid = out_valid_q;
   assign State_out = blk_q;
   assign table_ok  = table_ok_q;

endmodule

// File: tb/tb_aes_inv_sbyte_seq.sv
// Bench for aes_inv_sbyte_seq: LANES=1/4/16 instances, GF(2^8)-derived reference model,
// negedge scoreboard on the LANES=4 instance, directed and randomized blocks.
module tb_aes_inv_sbyte_seq;

   localparam int LAT [3] = '{17, 5, 2};
`ifdef AES_INV_TABLE_BUILD_EN
   localparam int EXP_READY = 256;
`else
   localparam int EXP_READY = 1;
`endif

   logic              clock = 1'b0;
   logic              reset;
   logic [255:0][7:0] sbox_p;
   logic [15:0][7:0]  sin;
   logic [2:0]        iv, ordy, irdy, ovld, tok;
   logic [15:0][7:0]  sout [3];

   always #5 clock = ~clock;

   aes_inv_sbyte_seq #(.LANES(1)) u_l1 (
      .clock(clock), .reset(reset), .S_Box(sbox_p), .in_valid(iv[0]), .in_ready(irdy[0]),
      .State_in(sin), .out_valid(ovld[0]), .out_ready(ordy[0]), .State_out(sout[0]),
      .table_ok(tok[0]));
   aes_inv_sbyte_seq #(.LANES(4)) u_l4 (
      .clock(clock), .reset(reset), .S_Box(sbox_p), .in_valid(iv[1]), .in_ready(irdy[1]),
      .State_in(sin), .out_valid(ovld[1]), .out_ready(ordy[1]), .State_out(sout[1]),
      .table_ok(tok[1]));
   aes_inv_sbyte_seq #(.LANES(16)) u_l16 (
      .clock(clock), .reset(reset), .S_Box(sbox_p), .in_valid(iv[2]), .in_ready(irdy[2]),
      .State_in(sin), .out_valid(ovld[2]), .out_ready(ordy[2]), .State_out(sout[2]),
      .table_ok(tok[2]));

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   // Reference model: S-box from its definition (GF inverse + affine map), then inverted by search.
   logic [7:0] sbox_m [256];
   logic [7:0] inv_m  [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] x;
      r = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   task automatic build_model();
      logic [7:0] iv_x;
      for (int x = 0; x < 256; x++) begin
         iv_x = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) iv_x = 8'(y);
         sbox_m[x] = iv_x ^ rotl(iv_x, 1) ^ rotl(iv_x, 2) ^ rotl(iv_x, 3) ^ rotl(iv_x, 4) ^ 8'h63;
      end
      for (int b = 0; b < 256; b++)
         for (int k = 0; k < 256; k++)
            if (sbox_m[k] == 8'(b)) inv_m[b] = 8'(k);
   endtask

   function automatic logic [15:0][7:0] model_blk(input logic [15:0][7:0] b);
      logic [15:0][7:0] r;
      for (int k = 0; k < 16; k++) r[k] = inv_m[b[k]];
      return r;
   endfunction

   function automatic logic [15:0][7:0] rand_blk();
      logic [15:0][7:0] r;
      for (int k = 0; k < 16; k++) r[k] = 8'($urandom);
      return r;
   endfunction

   // Scoreboard on the LANES=4 instance, sampled on the falling edge.
   logic [15:0][7:0] exp_q [$];
   logic [15:0][7:0] hold_val;
   logic [15:0][7:0] want;
   int n_acc = 0, n_out = 0, cyc = 0, acc_cyc = 0;
   logic hold_prev = 1'b0, ovld_prev = 1'b0;

   always @(negedge clock) begin
      cyc++;
      if (reset) begin
         n_acc    -= exp_q.size();
         exp_q.delete();
         hold_prev = 1'b0;
         ovld_prev = 1'b0;
      end else begin
         chk("handshake_overlap", 128'(irdy[1] & ovld[1]), 128'd0);
         if (hold_prev) begin
            chk("done_valid_hold", 128'(ovld[1]), 128'd1);
            chk("done_data_hold", sout[1], hold_val);
         end
         if (ovld[1] && !ovld_prev) chk("latency", 128'(cyc - acc_cyc), 128'(LAT[1] + 1));
         if (ovld[1] && ordy[1]) begin
            chk("inflight", 128'(exp_q.size()), 128'd1);
            if (exp_q.size() > 0) begin
               want = exp_q.pop_front();
               chk("block", sout[1], want);
            end
            n_out++;
         end
         if (iv[1] && irdy[1]) begin
            exp_q.push_back(model_blk(sin));
            n_acc++;
            acc_cyc = cyc;
         end
         hold_prev = ovld[1] && !ordy[1];
         hold_val  = sout[1];
         ovld_prev = ovld[1];
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input logic [15:0][7:0] b);
      logic hs;
      int   cnt;
      sin   = b;
      iv[1] = 1'b1;
      cnt   = 0;
      do begin
         @(negedge clock);
         hs = irdy[1];
         @(posedge clock);
         #1;
         cnt++;
      end while (!hs && cnt < 400);
      iv[1] = 1'b0;
      if (!hs) chk("send_timeout", 128'd0, 128'd1);
   endtask

   task automatic recv();
      logic hs;
      int   cnt;
      ordy[1] = 1'b1;
      cnt     = 0;
      do begin
         @(negedge clock);
         hs = ovld[1];
         @(posedge clock);
         #1;
         cnt++;
      end while (!hs && cnt < 100);
      ordy[1] = 1'b0;
      if (!hs) chk("recv_timeout", 128'd0, 128'd1);
   endtask

   // Same block into all three widths; each must match exp with its own latency.
   task automatic run_all(input string name, input logic [15:0][7:0] b,
                          input logic [15:0][7:0] exp);
      int               lat [3];
      logic [15:0][7:0] got [3];
      lat  = '{0, 0, 0};
      sin  = b;
      iv   = 3'b111;
      ordy = 3'b111;
      @(posedge clock);
      #1;
      iv = 3'b000;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clock);
         #1;
         for (int i = 0; i < 3; i++)
            if (ovld[i] && lat[i] == 0) begin
               lat[i] = c;
               got[i] = sout[i];
            end
      end
      ordy = 3'b000;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_lat%0d", name, i), 128'(lat[i]), 128'(LAT[i]));
         chk($sformatf("%s_out%0d", name, i), got[i], exp);
      end
   endtask

   logic [15:0][7:0] b, e;
   int cnt, acc0, out0, seen;
   logic rnd_on;

   initial begin
      iv = '0; ordy = '0; sin = '0; reset = 1'b1; rnd_on = 1'b0;
      build_model();
      for (int k = 0; k < 256; k++) sbox_p[k] = sbox_m[k];
      chk("model_sbox_00", 128'(sbox_m[8'h00]), 128'h63);
      chk("model_sbox_53", 128'(sbox_m[8'h53]), 128'hed);
      chk("model_inv_00", 128'(inv_m[8'h00]), 128'h52);
      chk("model_inv_ff", 128'(inv_m[8'hff]), 128'h7d);
      chk("model_inv_16", 128'(inv_m[8'h16]), 128'hff);
      chk("model_inv_63", 128'(inv_m[8'h63]), 128'h00);

      repeat (3) @(posedge clock);
      #1;
      chk("rst_in_ready", 128'(irdy), 128'd0);
      chk("rst_out_valid", 128'(ovld), 128'd0);
      chk("rst_table_ok", 128'(tok), 128'd0);
      for (int i = 0; i < 3; i++) chk($sformatf("rst_state_out%0d", i), sout[i], 128'd0);

      @(negedge clock);
      reset = 1'b0;
      cnt = 0;
      do begin
         @(posedge clock);
         #1;
         cnt++;
      end while (irdy != 3'b111 && cnt < 400);
      chk("ready_delay", 128'(cnt), 128'(EXP_READY));
      chk("table_ok", 128'(tok), 128'h7);

      b = {16{8'h63}};
      run_all("all63", b, 128'd0);
      b = {16{8'h63}};
      b[0] = 8'h00; b[15] = 8'hff; b[7] = 8'h16;
      e = '0;
      e[0] = 8'h52; e[15] = 8'h7d; e[7] = 8'hff;
      run_all("edge_bytes", b, e);
      b = rand_blk();
      run_all("rand", b, model_blk(b));

      // Output stall: DONE must hold while a second in_valid is ignored.
      b = rand_blk();
      send(b);
      cnt = 0;
      while (!ovld[1] && cnt < 50) begin
         @(posedge clock);
         #1;
         cnt++;
      end
      chk("stall_reached_done", 128'(ovld[1]), 128'd1);
      acc0  = n_acc;
      sin   = rand_blk();
      iv[1] = 1'b1;
      repeat (10) begin
         @(posedge clock);
         #1;
         chk("stall_in_ready", 128'(irdy[1]), 128'd0);
         chk("stall_out", sout[1], model_blk(b));
      end
      iv[1] = 1'b0;
      chk("stall_second_ignored", 128'(n_acc), 128'(acc0));
      recv();

      // Reset in the second PROC cycle aborts the block.
      ordy[1] = 1'b1;
      send(rand_blk());
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      seen = 0;
      repeat (20) begin
         @(posedge clock);
         #1;
         if (ovld[1]) seen++;
      end
      chk("aborted_block", 128'(seen), 128'd0);
      ordy[1] = 1'b0;
      b = rand_blk();
      send(b);
      recv();

      // Randomized traffic with input gaps and output backpressure.
      out0   = n_out;
      rnd_on = 1'b1;
      fork
         begin
            for (int n = 0; n < 1000; n++) begin
               repeat ($urandom_range(0, 3)) begin
                  @(posedge clock);
                  #1;
               end
               send(rand_blk());
            end
            rnd_on = 1'b0;
         end
         begin
            while (rnd_on) begin
               @(posedge clock);
               #1;
               ordy[1] = ($urandom_range(0, 3) != 0);
            end
         end
      join
      ordy[1] = 1'b1;
      repeat (30) @(posedge clock);
      #1;
      chk("drained", 128'(exp_q.size()), 128'd0);
      chk("random_outputs", 128'(n_out - out0), 128'd1000);
      chk("acc_vs_out", 128'(n_out), 128'(n_acc));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

endmodule

// File: doc/aes_inv_sbyte_seq.md
AES_INV_SBYTE_SEQ -- requirements
Module: aes_inv_sbyte_seq

Interface
REQ-001 SHALL have parameter LANES, default 4, giving state bytes inverse-substituted per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port S_Box  input  256x8  forward AES S-box table, static while reset is low.
REQ-005 SHALL have port in_valid  input  1  input block present.
REQ-006 SHALL have port in_ready  output  1  block accepted when in_valid and in_ready are both 1.
REQ-007 SHALL have port State_in  input  16x8 (index 0..4*Nb-1)  ciphertext-side state.
REQ-008 SHALL have port out_valid  output  1  State_out holds a result.
REQ-009 SHALL have port out_ready  input  1  result consumed when out_valid and out_ready are both 1.
REQ-010 SHALL have port State_out  output  16x8  State_out[k] = InvS(State_in[k]) for every k.
REQ-011 SHALL have port table_ok  output  1  inverse table valid.

Function
REQ-012 SHALL implement FSM states BUILD, IDLE, PROC, DONE.
REQ-013 BUILD: 8-bit counter k from 0 to 255, one entry per cycle, writes inv[S_Box[k]] = k; after k=255 -> IDLE, table_ok=1.
REQ-014 IDLE: in_ready=1; on handshake, capture State_in into a 16-byte register, lane index=0 -> PROC.
REQ-015 PROC: each cycle replace bytes [idx*LANES .. idx*LANES+LANES-1] with inv[] of themselves; after 16/LANES cycles -> DONE.
REQ-016 DONE: out_valid=1, State_out stable; on out_ready -> IDLE.
REQ-017 Latency: out_valid rises exactly 16/LANES+1 cycles after the accepting edge.
REQ-018 in_ready SHALL be 0 in BUILD, PROC and DONE; no overlap of input and output handshakes.
REQ-019 in_valid while in_ready=0 SHALL be ignored; State_in sampled only at handshake.
REQ-020 out_ready while out_valid=0 SHALL have no effect.
REQ-021 Lane index SHALL wrap to 0 on PROC exit; no byte processed twice.

Reset
REQ-022 Reset asserted: state=BUILD, k=0, in_ready=0, out_valid=0, table_ok=0, State_out=0, lane index=0.
REQ-023 Reset mid-PROC or mid-DONE SHALL abort the block without emitting it; mid-BUILD restarts at k=0.
REQ-024 Inverse table storage need not be reset; it is fully rewritten in BUILD.

Configuration
REQ-025 Macro AES_INV_TABLE_BUILD_EN defined: BUILD state present, table derived from S_Box; first in_ready 256 cycles after reset release.
REQ-026 Macro undefined: inv[] is the package constant Inv_S_Box, reset goes to IDLE, table_ok=1 one cycle after reset release, S_Box unused.

Structure
REQ-027 Package aes_const SHALL hold Nb and the Inv_S_Box constant; package aes_wire SHALL hold the FSM state enum and 16-byte state array typedef.
REQ-028 SHALL use one sub-module aes_inv_table: 256x8 table, one write port, LANES combinational read ports.

Verification
REQ-029 Reset release with FIPS-197 S_Box, macro defined -> in_ready=0 for 256 cycles, then table_ok=1, in_ready=1.
REQ-030 State_in all 0x63 -> State_out all 0x00; byte0=0x00 -> 0x52; byte15=0xFF -> 0x7D; 0x16 -> 0xFF.
REQ-031 LANES=1, 4, 16 with same block -> identical State_out, out_valid after 17, 5, 2 cycles.
REQ-032 out_ready held 0 for 10 cycles in DONE -> State_out stable, in_ready=0, second in_valid ignored.
REQ-033 Reset pulse in cycle 2 of PROC -> out_valid never asserts for that block; next block correct.
REQ-034 Random 1000 blocks vs software inverse model, random in_valid/out_ready gaps -> zero mismatches, none lost or duplicated.
